uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 50 +++++
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants, receiver FSM state encoding and parity helper shared by
// the UART receiver and transmitter.
package uart_pkg;

  // Default divider for a 16 MHz clock, 9600 baud and 16x oversampling.
  localparam int unsigned DEFAULT_BAUD_DIV   = 104;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Frame layout: start + 7 data bits (MSB first) + even parity + stop.
  localparam int unsigned DATA_BITS  = 7;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_e;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider that emits a registered one-clock tick
// every BAUD_DIV clocks. Clearing restarts the period so the caller can align
// the tick phase to an external event.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;
  logic          tick_d;

  // Next-state for the divider: wrap at LAST, restart on clear.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
  end

  // Divider and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 7E1 UART receiver with 16x oversampling. Samples each bit at its
// midpoint, checks even parity and the stop bit, and refuses to retrigger on a
// line held low after a framing error until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BCW = $clog2(DATA_BITS);

  // Mid-bit of the start bit is half a bit after the edge; later samples are
  // a whole bit apart.
  localparam logic [TW-1:0]  HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 prev_q;
  logic                 fall_s;
  logic                 clr_s;
  logic                 tick_s;

  uart_rx_state_e       state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 busy_q;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection;
  // all three idle high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_s = prev_q & ~sync2_q;
  // Restart the tick phase on the start edge so mid-bit samples line up.
  assign clr_s  = (state_q == ST_IDLE) & fall_s;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr_s),
    .tick(tick_s)
  );

  // Receive FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          busy_q     <= 1'b0;
          if (fall_s) begin
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (tick_s) begin
            if (tick_cnt_q == HALF_LAST) begin
              tick_cnt_q <= '0;
              if (!sync2_q) begin
                state_q <= ST_DATA;
                busy_q  <= 1'b1;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state_q <= ST_IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (tick_s) begin
            if (tick_cnt_q == FULL_LAST) begin
              tick_cnt_q <= '0;
              // MSB arrives first, so it ends up in the top bit.
              shift_q    <= {shift_q[DATA_BITS-2:0], sync2_q};
              if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= ST_PARITY;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (tick_s) begin
            if (tick_cnt_q == FULL_LAST) begin
              tick_cnt_q <= '0;
              parity_q   <= sync2_q;
              state_q    <= ST_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (tick_s) begin
            if (tick_cnt_q == FULL_LAST) begin
              tick_cnt_q <= '0;
              if (sync2_q) begin
                rx_data_q    <= shift_q;
                rx_valid_q   <= 1'b1;
                parity_err_q <= parity_q ^ even_parity(shift_q);
                busy_q       <= 1'b0;
                state_q      <= ST_IDLE;
              end else begin
                // Bad stop bit: keep the previous word and wait for idle.
                frame_err_q <= 1'b1;
                state_q     <= ST_WAIT_IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (sync2_q) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized checks of uart_rx against a
// frame-level reference model (one expected word per well-formed frame).
module tb_uart_rx;

  localparam int BAUD_DIV   = 8;
  localparam int OVERSAMPLE = 16;
  localparam int BIT        = BAUD_DIV * OVERSAMPLE;
  localparam int GLITCH     = (BIT * 400) / 1664;
  localparam int LAT_LO     = (BIT * 19) / 2;
  localparam int LAT_HI     = LAT_LO + 2 * BAUD_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [6:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_rx #(
    .BAUD_DIV  (BAUD_DIV),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency measurement.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every rx_valid word, count frame errors and protocol breaks.
  logic [6:0] v_data_q[$];
  logic       v_perr_q[$];
  int         last_valid_cyc = 0;
  int         n_ferr  = 0;
  int         n_proto = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin
      v_data_q.push_back(rx_data);
      v_perr_q.push_back(parity_err);
      last_valid_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if ((rx_valid && frame_err) || (rx_valid && prev_valid) || (frame_err && prev_ferr))
      n_proto <= n_proto + 1;
    prev_valid <= rx_valid;
    prev_ferr  <= frame_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit period; optional short inverted pulse well before mid-bit.
  task automatic drive_bit(input logic b, input logic glitch);
    if (glitch) begin
      rx_in = b;  wait_clks(BIT / 8);
      rx_in = ~b; wait_clks(BIT / 8);
      rx_in = b;  wait_clks(BIT - BIT / 4);
    end else begin
      rx_in = b;  wait_clks(BIT);
    end
  endtask

  int start_cyc = 0;
  task automatic send_frame(input logic [6:0] d, input logic p, input logic s, input logic glitch);
    start_cyc = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) drive_bit(d[i], glitch);
    drive_bit(p, glitch);
    drive_bit(s, glitch);
  endtask

  typedef struct packed {
    logic [6:0] data;
    logic       par;
    logic [6:0] exp_data;
    logic       exp_perr;
  } vec_t;
  vec_t vecs[6];

  logic [6:0] exp_d_q[$];
  logic       exp_p_q[$];

  initial begin
    int base;
    int f0;
    int lat;
    logic [6:0] saved_d;
    logic       saved_p;

    vecs[0] = '{7'b1000101, 1'b1, 7'b1000101, 1'b0};
    vecs[1] = '{7'b1000101, 1'b0, 7'b1000101, 1'b1};
    vecs[2] = '{7'h7F,      1'b1, 7'h7F,      1'b0};
    vecs[3] = '{7'h00,      1'b0, 7'h00,      1'b0};
    vecs[4] = '{7'h2A,      1'b1, 7'h2A,      1'b0};
    vecs[5] = '{7'h55,      1'b1, 7'h55,      1'b1};

    // Reset state.
    rst = 1'b1;
    rx_in = 1'b1;
    wait_clks(5);
    check("rst_rx_data", rx_data, 7'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    wait_clks(BIT);

    // Table of single frames with idle gaps.
    for (int v = 0; v < 6; v++) begin
      base = v_data_q.size();
      f0   = n_ferr;
      send_frame(vecs[v].data, vecs[v].par, 1'b1, 1'b0);
      check("tbl_valid_count", v_data_q.size() - base, 1);
      check("tbl_ferr_count", n_ferr - f0, 0);
      check("tbl_rx_data", rx_data, vecs[v].exp_data);
      check("tbl_parity_err", parity_err, vecs[v].exp_perr);
      lat = last_valid_cyc - start_cyc;
      checks++;
      if (lat < LAT_LO || lat > LAT_HI) begin
        failures++;
        $display("FAIL tbl_latency actual=%0d expected=%0d..%0d", lat, LAT_LO, LAT_HI);
      end
      wait_clks(BIT);
    end

    // Reset in the middle of the data bits, then a complete frame 0x12.
    base = v_data_q.size();
    f0   = n_ferr;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", rx_data, 7'h00);
    check("midrst_parity_err", parity_err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    rx_in = 1'b1;
    wait_clks(BIT);
    rst = 1'b0;
    wait_clks(2 * BIT);
    check("midrst_no_valid", v_data_q.size() - base, 0);
    check("midrst_no_ferr", n_ferr - f0, 0);
    send_frame(7'h12, 1'b0, 1'b1, 1'b0);
    check("midrst_valid_count", v_data_q.size() - base, 1);
    check("midrst_rx_data_12", rx_data, 7'h12);
    check("midrst_perr_12", parity_err, 1'b0);
    wait_clks(BIT);

    // Framing error: stop bit low, line held low 3 more bit periods.
    base    = v_data_q.size();
    f0      = n_ferr;
    saved_d = rx_data;
    saved_p = parity_err;
    send_frame(7'h2A, 1'b1, 1'b0, 1'b0);
    wait_clks(3 * BIT);
    check("ferr_count", n_ferr - f0, 1);
    check("ferr_no_valid", v_data_q.size() - base, 0);
    check("ferr_rx_data_held", rx_data, saved_d);
    check("ferr_perr_held", parity_err, saved_p);
    check("ferr_busy_while_low", busy, 1'b1);
    rx_in = 1'b1;
    wait_clks(8);
    check("ferr_busy_after_high", busy, 1'b0);
    send_frame(7'h33, 1'b0, 1'b1, 1'b0);
    check("ferr_next_valid", v_data_q.size() - base, 1);
    check("ferr_next_data", rx_data, 7'h33);
    check("ferr_next_perr", parity_err, 1'b0);
    wait_clks(BIT);

    // Short low glitch on the idle line must be rejected.
    base = v_data_q.size();
    f0   = n_ferr;
    rx_in = 1'b0;
    wait_clks(GLITCH);
    rx_in = 1'b1;
    wait_clks(BIT / 4);
    check("glitch_busy_mid", busy, 1'b0);
    wait_clks(2 * BIT);
    check("glitch_busy", busy, 1'b0);
    check("glitch_no_valid", v_data_q.size() - base, 0);
    check("glitch_no_ferr", n_ferr - f0, 0);

    // Back-to-back frames with no idle gap.
    base = v_data_q.size();
    send_frame(7'h45, 1'b1, 1'b1, 1'b0);
    send_frame(7'h3A, 1'b0, 1'b1, 1'b0);
    check("b2b_count", v_data_q.size() - base, 2);
    if (v_data_q.size() - base == 2) begin
      check("b2b_data0", v_data_q[base], 7'h45);
      check("b2b_perr0", v_perr_q[base], 1'b0);
      check("b2b_data1", v_data_q[base + 1], 7'h3A);
      check("b2b_perr1", v_perr_q[base + 1], 1'b0);
    end
    wait_clks(BIT);

    // Randomized frames: random data, parity, gaps and off-sample glitches.
    base = v_data_q.size();
    f0   = n_ferr;
    for (int n = 0; n < 24; n++) begin
      logic [6:0] d;
      logic       p;
      logic       g;
      int         gap;
      d   = 7'($urandom_range(0, 127));
      p   = (($countones(d) % 2) == 1);
      if ($urandom_range(0, 3) == 0) p = ~p;
      g   = ($urandom_range(0, 1) == 1);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 2 * BIT);
      exp_d_q.push_back(d);
      exp_p_q.push_back(p != (($countones(d) % 2) == 1));
      send_frame(d, p, 1'b1, g);
      if (gap > 0) wait_clks(gap);
    end
    wait_clks(BIT);
    check("rand_count", v_data_q.size() - base, exp_d_q.size());
    check("rand_no_ferr", n_ferr - f0, 0);
    for (int k = 0; k < exp_d_q.size(); k++) begin
      if (base + k < v_data_q.size()) begin
        check("rand_data", v_data_q[base + k], exp_d_q[k]);
        check("rand_perr", v_perr_q[base + k], exp_p_q[k]);
      end
    end

    check("pulse_protocol", n_proto, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
